// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch stage.
//   - fetch_state_e  : fetch sequencer states (INIT/RUN/BUBBLE/HALT)
//   - redirect_src_e : which source (if any) redirected fetch this cycle
//   - default widths and reset PC used by fetch_pc_unit
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT     = 32;
  localparam int unsigned IMEM_AW_DEFAULT  = 12;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_HALT   = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_JUMP   = 2'd1,
    REDIR_BRANCH = 2'd2
  } redirect_src_e;

  function automatic logic is_redirect(input redirect_src_e src);
    return src != REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch-stage control and F/D bus.
//   Control (master -> slave): stall, jump_en, jump_target, br_taken, br_target
//   Status  (slave -> master): imem_addr, pc, fd_pc, fd_pc_plus1, fd_valid,
//                              fetch_fault
//   slave  : the fetch PC unit
//   master : the surrounding pipeline (decode/execute) or a testbench
interface fetch_pc_unit_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned IMEM_AW = 12
);

  logic               stall;
  logic               jump_en;
  logic [PC_W-1:0]    jump_target;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [IMEM_AW-1:0] imem_addr;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    fd_pc;
  logic [PC_W-1:0]    fd_pc_plus1;
  logic               fd_valid;
  logic               fetch_fault;

  modport master (
    output stall, jump_en, jump_target, br_taken, br_target,
    input  imem_addr, pc, fd_pc, fd_pc_plus1, fd_valid, fetch_fault
  );

  modport slave (
    input  stall, jump_en, jump_target, br_taken, br_target,
    output imem_addr, pc, fd_pc, fd_pc_plus1, fd_valid, fetch_fault
  );

endinterface

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux.
//   Priority: br_taken > jump_en > stall > pc+1 (modulo 2^PC_W).
//   Inputs : pc, stall, jump_en, jump_target, br_taken, br_target
//   Outputs: next_pc, redirect_src (NONE/JUMP/BRANCH)
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_target,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] next_pc,
  output redirect_src_e   redirect_src
);

  always_comb begin
    next_pc      = pc + PC_W'(1);
    redirect_src = REDIR_NONE;
    // The branch comes from an older instruction than the jump in decode,
    // so it wins; either redirect overrides a stall.
    if (br_taken) begin
      next_pc      = br_target;
      redirect_src = REDIR_BRANCH;
    end else if (jump_en) begin
      next_pc      = jump_target;
      redirect_src = REDIR_JUMP;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC sequencer for the 32-bit pipelined CPU.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : fetch_pc_unit_if.slave (redirect/stall in; pc, imem_addr and
//             F/D fields out)
// Every accepted redirect clears fd_valid for one cycle (bubble); the target
// is fetched the next cycle and becomes valid in F/D the cycle after.
// Optional build macro FETCH_TARGET_CHECK_EN: a redirect whose target has
// nonzero bits above the instruction-memory address range raises a sticky
// fetch_fault and parks the unit in HALT until reset. Without it,
// fetch_fault is 0 and imem_addr silently truncates.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEFAULT,
  parameter int unsigned     IMEM_AW  = IMEM_AW_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset_n,
  fetch_pc_unit_if.slave  bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fd_pc_q;
  logic [PC_W-1:0] fd_pc_plus1_q;
  logic            fd_valid_q;
  logic            fault_q;

  logic [PC_W-1:0] next_pc;
  redirect_src_e   redirect_src;
  logic            redirect;
  logic            target_fault;

  logic            pc_load;
  logic            fd_load;
  logic            fd_clear;
  logic            fault_set;

  pc_next_sel #(
    .PC_W(PC_W)
  ) u_next_sel (
    .pc           (pc_q),
    .stall        (bus.stall),
    .jump_en      (bus.jump_en),
    .jump_target  (bus.jump_target),
    .br_taken     (bus.br_taken),
    .br_target    (bus.br_target),
    .next_pc      (next_pc),
    .redirect_src (redirect_src)
  );

  assign redirect = is_redirect(redirect_src);

`ifdef FETCH_TARGET_CHECK_EN
  // next_pc equals the selected target whenever redirect is set.
  assign target_fault = redirect && (|next_pc[PC_W-1:IMEM_AW]);
`else
  assign target_fault = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN, ST_BUBBLE: begin
        if (target_fault) begin
          state_d = ST_HALT;
        end else if (redirect) begin
          state_d = ST_BUBBLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  // Output/control logic: register load enables for the datapath
  always_comb begin
    pc_load   = 1'b0;
    fd_load   = 1'b0;
    fd_clear  = 1'b0;
    fault_set = 1'b0;
    if (state_q == ST_RUN || state_q == ST_BUBBLE) begin
      if (target_fault) begin
        fault_set = 1'b1;
        fd_clear  = 1'b1;
      end else if (redirect) begin
        pc_load  = 1'b1;
        fd_clear = 1'b1;
      end else if (!bus.stall) begin
        pc_load = 1'b1;
        fd_load = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      fd_pc_q       <= '0;
      fd_pc_plus1_q <= '0;
      fd_valid_q    <= 1'b0;
    end else begin
      if (pc_load) begin
        pc_q <= next_pc;
      end
      if (fd_load) begin
        // On a sequential advance next_pc is pc+1, reused as the link value.
        fd_pc_q       <= pc_q;
        fd_pc_plus1_q <= next_pc;
        fd_valid_q    <= 1'b1;
      end else if (fd_clear) begin
        fd_valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_TARGET_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fault_q = fault_set;
`endif

  assign bus.imem_addr   = pc_q[IMEM_AW-1:0];
  assign bus.pc          = pc_q;
  assign bus.fd_pc       = fd_pc_q;
  assign bus.fd_pc_plus1 = fd_pc_plus1_q;
  assign bus.fd_valid    = fd_valid_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: self-checking bench for fetch_pc_unit.
// Directed vector table, hand-written corner sequences and a randomized
// phase compared against a behavioural model of the fetch sequencer.
// Honours FETCH_TARGET_CHECK_EN when the design is built with it.
module tb_fetch_pc_unit;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned IMEM_AW = 12;
`ifdef FETCH_TARGET_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  fetch_pc_unit_if #(.PC_W(PC_W), .IMEM_AW(IMEM_AW)) bus ();

  fetch_pc_unit #(
    .PC_W    (PC_W),
    .IMEM_AW (IMEM_AW),
    .RESET_PC(32'h0)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the bubble is just fd_valid=0, the INIT cycle is a
  // "first cycle after reset" flag, HALT is a "halted" flag.
  logic [31:0] m_pc, m_fd_pc, m_fd_p1;
  bit          m_valid, m_fault, m_first, m_halted;

  task automatic model_edge(input bit rst, input bit st, input bit je,
                            input logic [31:0] jt, input bit bt,
                            input logic [31:0] btg);
    logic [31:0] tgt;
    if (!rst) begin
      m_pc = 32'h0; m_fd_pc = 32'h0; m_fd_p1 = 32'h0;
      m_valid = 0; m_fault = 0; m_first = 1; m_halted = 0;
    end else if (m_first) begin
      m_first = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (bt || je) begin
      tgt = bt ? btg : jt;
      m_valid = 0;
      if (CHECK_EN && (tgt >> IMEM_AW) != 0) begin
        m_fault = 1; m_halted = 1;
      end else begin
        m_pc = tgt;
      end
    end else if (!st) begin
      m_fd_pc = m_pc; m_fd_p1 = m_pc + 32'd1; m_valid = 1; m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_imem;
    exp_imem = {20'h0, m_pc[IMEM_AW-1:0]};
    check({tag, ".pc"},       bus.pc,                m_pc);
    check({tag, ".fd_pc"},    bus.fd_pc,             m_fd_pc);
    check({tag, ".fd_p1"},    bus.fd_pc_plus1,       m_fd_p1);
    check({tag, ".fd_valid"}, {31'h0, bus.fd_valid}, {31'h0, m_valid});
    check({tag, ".fault"},    {31'h0, bus.fetch_fault}, {31'h0, m_fault});
    check({tag, ".imem"},     {20'h0, bus.imem_addr}, exp_imem);
  endtask

  // Drive one cycle of inputs, clock, then sample 1 time unit after the edge.
  task automatic step(input bit rst, input bit st, input bit je,
                      input logic [31:0] jt, input bit bt,
                      input logic [31:0] btg);
    reset_n         = rst;
    bus.stall       = st;
    bus.jump_en     = je;
    bus.jump_target = jt;
    bus.br_taken    = bt;
    bus.br_target   = btg;
    @(posedge clock);
    model_edge(rst, st, je, jt, bt, btg);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 32'h0, 0, 32'h0);
  endtask

  typedef struct {
    bit          rst, st, je;
    logic [31:0] jt;
    bit          bt;
    logic [31:0] btg;
    logic [31:0] e_pc, e_fd, e_p1;
    bit          e_v;
  } vec_t;

  function automatic vec_t mkv(bit rst, bit st, bit je, logic [31:0] jt,
                               bit bt, logic [31:0] btg, logic [31:0] e_pc,
                               logic [31:0] e_fd, logic [31:0] e_p1, bit e_v);
    vec_t v;
    v.rst = rst; v.st = st; v.je = je; v.jt = jt; v.bt = bt; v.btg = btg;
    v.e_pc = e_pc; v.e_fd = e_fd; v.e_p1 = e_p1; v.e_v = e_v;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [31:0] held_pc;
    logic [31:0] jt_r, bt_r, exp_imem;
    bit r_rst, r_st, r_je, r_bt;

    //            rst st je jt       bt btg      pc       fd_pc    fd_p1   v
    tbl[0]  = mkv(0, 0, 0, 32'h0,   0, 32'h0,   32'h0,   32'h0,   32'h0,  0);
    tbl[1]  = mkv(0, 0, 0, 32'h0,   0, 32'h0,   32'h0,   32'h0,   32'h0,  0);
    tbl[2]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h0,   32'h0,   32'h0,  0); // INIT
    tbl[3]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h1,   32'h0,   32'h1,  1);
    tbl[4]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h2,   32'h1,   32'h2,  1);
    tbl[5]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h3,   32'h2,   32'h3,  1);
    tbl[6]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h4,   32'h3,   32'h4,  1);
    tbl[7]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h5,   32'h4,   32'h5,  1);
    tbl[8]  = mkv(1, 0, 1, 32'h40,  0, 32'h0,   32'h40,  32'h4,   32'h5,  0); // jump
    tbl[9]  = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h41,  32'h40,  32'h41, 1);
    tbl[10] = mkv(1, 1, 1, 32'h20,  1, 32'h80,  32'h80,  32'h40,  32'h41, 0); // br wins
    tbl[11] = mkv(1, 1, 0, 32'h0,   0, 32'h0,   32'h80,  32'h40,  32'h41, 0); // stall in bubble
    tbl[12] = mkv(1, 0, 0, 32'h0,   0, 32'h0,   32'h81,  32'h80,  32'h81, 1);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].je, tbl[i].jt, tbl[i].bt, tbl[i].btg);
      exp_imem = {20'h0, tbl[i].e_pc[IMEM_AW-1:0]};
      check($sformatf("tbl%0d.pc", i),       bus.pc,                 tbl[i].e_pc);
      check($sformatf("tbl%0d.fd_pc", i),    bus.fd_pc,              tbl[i].e_fd);
      check($sformatf("tbl%0d.fd_p1", i),    bus.fd_pc_plus1,        tbl[i].e_p1);
      check($sformatf("tbl%0d.fd_valid", i), {31'h0, bus.fd_valid},  {31'h0, tbl[i].e_v});
      check($sformatf("tbl%0d.imem", i),     {20'h0, bus.imem_addr}, exp_imem);
    end

    // Stall for 3 cycles at pc=9.
    step(0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 9; i++) idle();
    check("stall.pre_pc", bus.pc, 32'h9);
    check("stall.pre_fd", bus.fd_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'h0, 0, 32'h0);
      check("stall.pc", bus.pc, 32'h9);
      check("stall.fd", bus.fd_pc, 32'h8);
      check("stall.v",  {31'h0, bus.fd_valid}, 32'h1);
    end
    idle();
    check("stall.resume_pc", bus.pc, 32'hA);
    check("stall.resume_fd", bus.fd_pc, 32'h9);
    check_model("stall");

`ifndef FETCH_TARGET_CHECK_EN
    // Branch to the top word, then pc+1 wraps to 0.
    step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    check("wrap.pc",   bus.pc, 32'hFFFF_FFFF);
    check("wrap.imem", {20'h0, bus.imem_addr}, 32'hFFF);
    check("wrap.v",    {31'h0, bus.fd_valid}, 32'h0);
    idle();
    check("wrap.pc2",   bus.pc, 32'h0);
    check("wrap.imem2", {20'h0, bus.imem_addr}, 32'h0);
    check("wrap.fd",    bus.fd_pc, 32'hFFFF_FFFF);
    check("wrap.fd_p1", bus.fd_pc_plus1, 32'h0);
    check("wrap.v2",    {31'h0, bus.fd_valid}, 32'h1);
`endif

    // Reset asserted while in the bubble.
    step(1, 0, 0, 32'h0, 1, 32'h10);
    check("rbub.pc", bus.pc, 32'h10);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    check("rbub.rst_pc", bus.pc, 32'h0);
    check("rbub.rst_v",  {31'h0, bus.fd_valid}, 32'h0);
    check("rbub.rst_fd", bus.fd_pc, 32'h0);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    check("rbub.init_pc", bus.pc, 32'h0);
    check("rbub.init_v",  {31'h0, bus.fd_valid}, 32'h0);
    idle();
    check("rbub.run_fd", bus.fd_pc, 32'h0);
    check("rbub.run_v",  {31'h0, bus.fd_valid}, 32'h1);
    check("rbub.run_pc", bus.pc, 32'h1);

    // Out-of-range jump target.
    idle();
    held_pc = bus.pc;
    step(1, 0, 1, 32'hFFFF_F000, 0, 32'h0);
`ifdef FETCH_TARGET_CHECK_EN
    check("oor.fault", {31'h0, bus.fetch_fault}, 32'h1);
    check("oor.pc",    bus.pc, held_pc);
    check("oor.v",     {31'h0, bus.fd_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, (i == 1), 32'h30, (i == 2), 32'h50);
      check("halt.fault", {31'h0, bus.fetch_fault}, 32'h1);
      check("halt.pc",    bus.pc, held_pc);
      check("halt.v",     {31'h0, bus.fd_valid}, 32'h0);
    end
    step(0, 0, 0, 32'h0, 0, 32'h0);
    check("halt.rst_fault", {31'h0, bus.fetch_fault}, 32'h0);
`else
    check("oor.pc",    bus.pc, 32'hFFFF_F000);
    check("oor.imem",  {20'h0, bus.imem_addr}, 32'h0);
    check("oor.fault", {31'h0, bus.fetch_fault}, 32'h0);
`endif
    check_model("oor");

    // Randomized phase against the model.
    step(0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 99) >= 3);
      r_st  = ($urandom_range(0, 3) == 0);
      r_je  = ($urandom_range(0, 9) == 0);
      r_bt  = ($urandom_range(0, 11) == 0);
      jt_r  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      bt_r  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      step(r_rst, r_st, r_je, jt_r, r_bt, bt_r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
